// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM gate-drive protection stage.
package pwm_pkg;

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMING   = 2'd1,
    RUN      = 2'd2,
    FAULT    = 2'd3
  } pwm_state_e;

  localparam int unsigned FAULT_EXT   = 0;
  localparam int unsigned FAULT_SHOOT = 1;
  localparam int unsigned FAULT_CNT_W = 8;

endpackage

// File: rtl/pwm_leg_filter.sv
// Minimum-pulse filter for one PWM leg: the gate turns on only after MIN_PULSE
// consecutive high samples and drops on the first low sample.
module pwm_leg_filter #(
  parameter int unsigned MIN_PULSE = 10,
  parameter int unsigned CNT_W     = 8
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_leg_in,
  output logic o_gate_out
);

  localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_PULSE);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q, gate_d;

  always_comb begin
    cnt_d = '0;
    if (!i_clear && i_leg_in) begin
      cnt_d = (cnt_q >= MinCnt) ? MinCnt : cnt_q + 1'b1;
    end
    // Decided from the next count so the gate rises on the edge the count saturates.
    gate_d = !i_clear && i_leg_in && (cnt_d == MinCnt);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt_q  <= '0;
      gate_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gate_q <= gate_d;
    end
  end

  assign o_gate_out = gate_q;

endmodule

// File: rtl/pwm_gate_guard.sv
// Gate-drive guard between the PWM generator and the half-bridge driver.
// Define PWM_GATE_GUARD_FAULT_COUNT_EN to add the saturating o_fault_count output.
module pwm_gate_guard
  import pwm_pkg::*;
#(
  parameter int unsigned MIN_PULSE    = 10,
  parameter int unsigned FAULT_FILTER = 4,
  parameter int unsigned CNT_W        = 8
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_enable,
  input  logic       i_pwm_high,
  input  logic       i_pwm_low,
  input  logic       i_fault_n,
  input  logic       i_fault_clear,
  output logic       o_gate_high,
  output logic       o_gate_low,
  output logic       o_ready,
  output logic       o_fault,
  output logic [1:0] o_fault_code
`ifdef PWM_GATE_GUARD_FAULT_COUNT_EN
  ,
  output logic [FAULT_CNT_W-1:0] o_fault_count
`endif
);

  localparam logic [CNT_W-1:0] FltMax = CNT_W'(FAULT_FILTER);

  pwm_state_e       state_q, state_d;
  logic [1:0]       code_q, code_d;
  logic [1:0]       cause;
  logic [CNT_W-1:0] flt_cnt_q, flt_cnt_d;
  logic             sync1_q, sync2_q;
  logic             ext_fault, leg_clear;
  logic             gate_high_raw, gate_low_raw;

  always_comb begin
    flt_cnt_d = '0;
    if (!sync2_q) begin
      flt_cnt_d = (flt_cnt_q >= FltMax) ? FltMax : flt_cnt_q + 1'b1;
    end
    ext_fault = (flt_cnt_d == FltMax);

    cause              = '0;
    cause[FAULT_EXT]   = ext_fault;
    cause[FAULT_SHOOT] = i_pwm_high && i_pwm_low && (state_q == ARMING || state_q == RUN);

    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      DISARMED: begin
        if (ext_fault) begin
          state_d = FAULT;
          code_d  = cause;
        end else if (i_enable) begin
          state_d = ARMING;
        end
      end
      ARMING, RUN: begin
        if (|cause) begin
          state_d = FAULT;
          code_d  = cause;
        end else if (!i_enable) begin
          state_d = DISARMED;
        end else if (state_q == ARMING && !i_pwm_high && !i_pwm_low) begin
          state_d = RUN;
        end
      end
      FAULT: begin
        code_d = code_q | cause;
        if (i_fault_clear && !i_enable && !ext_fault) begin
          state_d = DISARMED;
          code_d  = '0;
        end
      end
      default: state_d = DISARMED;
    endcase

    // Filters follow the next state so a fault edge also kills the gate on that edge.
    leg_clear = (state_d != RUN);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q   <= DISARMED;
      code_q    <= '0;
      flt_cnt_q <= '0;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      flt_cnt_q <= flt_cnt_d;
      sync1_q   <= i_fault_n;
      sync2_q   <= sync1_q;
    end
  end

  pwm_leg_filter #(
    .MIN_PULSE (MIN_PULSE),
    .CNT_W     (CNT_W)
  ) u_filt_high (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (leg_clear),
    .i_leg_in   (i_pwm_high),
    .o_gate_out (gate_high_raw)
  );

  pwm_leg_filter #(
    .MIN_PULSE (MIN_PULSE),
    .CNT_W     (CNT_W)
  ) u_filt_low (
    .i_clk      (i_clk),
    .i_reset_n  (i_reset_n),
    .i_clear    (leg_clear),
    .i_leg_in   (i_pwm_low),
    .o_gate_out (gate_low_raw)
  );

  // Interlock: each gate is masked by the other so both can never drive together.
  assign o_gate_high  = gate_high_raw & ~gate_low_raw;
  assign o_gate_low   = gate_low_raw & ~gate_high_raw;
  assign o_ready      = (state_q == RUN);
  assign o_fault      = (state_q == FAULT);
  assign o_fault_code = code_q;

`ifdef PWM_GATE_GUARD_FAULT_COUNT_EN
  logic                   fault_entry;
  logic [FAULT_CNT_W-1:0] fcnt_q;

  assign fault_entry = (state_q != FAULT) && (state_d == FAULT);

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      fcnt_q <= '0;
    end else if (fault_entry && (fcnt_q != '1)) begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  assign o_fault_count = fcnt_q;
`endif

endmodule

// File: tb/tb_pwm_gate_guard.sv
// Scoreboard bench for pwm_gate_guard: the driver queues expected outputs per edge,
// a separate monitor pops and compares them after each rising edge.
module tb_pwm_gate_guard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, enable, pwm_high, pwm_low, fault_n, fault_clear;
  logic       gate_high, gate_low, ready, fault;
  logic [1:0] fault_code;
`ifdef PWM_GATE_GUARD_FAULT_COUNT_EN
  logic [7:0] fault_count;
`endif

  typedef struct {
    string      nm;
    logic       gh;
    logic       gl;
    logic       rdy;
    logic       flt;
    logic [1:0] code;
    int         fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_fc  = 0;

  pwm_gate_guard #(
    .MIN_PULSE    (10),
    .FAULT_FILTER (4),
    .CNT_W        (8)
  ) dut (
    .i_clk         (clk),
    .i_reset_n     (reset_n),
    .i_enable      (enable),
    .i_pwm_high    (pwm_high),
    .i_pwm_low     (pwm_low),
    .i_fault_n     (fault_n),
    .i_fault_clear (fault_clear),
    .o_gate_high   (gate_high),
    .o_gate_low    (gate_low),
    .o_ready       (ready),
    .o_fault       (fault),
    .o_fault_code  (fault_code)
`ifdef PWM_GATE_GUARD_FAULT_COUNT_EN
    ,
    .o_fault_count (fault_count)
`endif
  );

  // Apply one input vector before the next rising edge and queue the outputs expected after it.
  task automatic drv(input string nm, input logic rst, input logic en, input logic h,
                     input logic l, input logic fn, input logic clr, input logic egh,
                     input logic egl, input logic erdy, input logic eflt,
                     input logic [1:0] ecode);
    exp_t e;
    @(negedge clk);
    reset_n     = rst;
    enable      = en;
    pwm_high    = h;
    pwm_low     = l;
    fault_n     = fn;
    fault_clear = clr;
    e.nm   = nm;
    e.gh   = egh;
    e.gl   = egl;
    e.rdy  = erdy;
    e.flt  = eflt;
    e.code = ecode;
    e.fc   = exp_fc;
    q.push_back(e);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        logic ok;
        int   got_fc;
        e      = q.pop_front();
        got_fc = e.fc;
        ok = (gate_high === e.gh) && (gate_low === e.gl) && (ready === e.rdy) &&
             (fault === e.flt) && (fault_code === e.code);
`ifdef PWM_GATE_GUARD_FAULT_COUNT_EN
        got_fc = int'(fault_count);
        ok     = ok && (fault_count === 8'(e.fc));
`endif
        n_tests++;
        if (!ok) begin
          n_fail++;
          $display("FAIL %s: got gh=%b gl=%b rdy=%b flt=%b code=%b cnt=%0d, want gh=%b gl=%b rdy=%b flt=%b code=%b cnt=%0d",
                   e.nm, gate_high, gate_low, ready, fault, fault_code, got_fc,
                   e.gh, e.gl, e.rdy, e.flt, e.code, e.fc);
        end
      end
    end
  end

  initial begin
    reset_n     = 1'b0;
    enable      = 1'b0;
    pwm_high    = 1'b0;
    pwm_low     = 1'b0;
    fault_n     = 1'b1;
    fault_clear = 1'b0;

    for (int i = 0; i < 3; i++) drv("reset", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);

    // Arming waits for a deadtime window
    for (int i = 0; i < 3; i++) drv("arm_wait", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    drv("arm_run", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);

    for (int i = 0; i < 40; i++)
      drv("min_pulse_hi", 1, 1, 1, 0, 1, 0, logic'(i >= 9), 0, 1, 0, 2'b00);
    for (int i = 0; i < 2; i++) drv("min_pulse_fall", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);

    for (int i = 0; i < 9; i++) drv("short_pulse", 1, 1, 1, 0, 1, 0, 0, 0, 1, 0, 2'b00);
    for (int i = 0; i < 2; i++) drv("short_fall", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);

    for (int i = 0; i < 12; i++)
      drv("low_leg", 1, 1, 0, 1, 1, 0, 0, logic'(i >= 9), 1, 0, 2'b00);
    drv("low_fall", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);

    // Shoot-through while the high gate is on
    for (int i = 0; i < 12; i++)
      drv("pre_shoot", 1, 1, 1, 0, 1, 0, logic'(i >= 9), 0, 1, 0, 2'b00);
    exp_fc = 1;
    drv("shoot", 1, 1, 1, 1, 1, 0, 0, 0, 0, 1, 2'b10);
    for (int i = 0; i < 2; i++) drv("clr_en_hi", 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 2'b10);
    drv("clr_ok", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00);

    drv("rearm", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    drv("rearm_run", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);

    // Three-cycle fault glitch is filtered out
    for (int i = 0; i < 3; i++) drv("glitch", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2'b00);
    for (int i = 0; i < 4; i++) drv("glitch_rec", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);

    for (int i = 0; i < 10; i++)
      drv("pre_ext", 1, 1, 1, 0, 1, 0, logic'(i >= 9), 0, 1, 0, 2'b00);
    for (int i = 0; i < 5; i++) drv("ext_filter", 1, 1, 1, 0, 0, 0, 1, 0, 1, 0, 2'b00);
    exp_fc = 2;
    drv("ext_fault", 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 2'b01);
    drv("clr_while_ext", 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b01);
    for (int i = 0; i < 3; i++) drv("clr_en_hi2", 1, 1, 0, 0, 1, 1, 0, 0, 0, 1, 2'b01);
    drv("clr_ok2", 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2'b00);

    // Reset while the high gate is driving
    drv("rearm2", 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    drv("rearm2_run", 1, 1, 0, 0, 1, 0, 0, 0, 1, 0, 2'b00);
    for (int i = 0; i < 10; i++)
      drv("pre_reset", 1, 1, 1, 0, 1, 0, logic'(i >= 9), 0, 1, 0, 2'b00);
    exp_fc = 0;
    for (int i = 0; i < 2; i++) drv("reset_mid", 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 2'b00);
    drv("post_reset", 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 2'b00);

    repeat (2) @(posedge clk);
    #4;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_gate_guard.md
# pwm_gate_guard

Gate-drive protection stage placed directly downstream of the center-aligned PWM generator, between its high/low leg outputs and the half-bridge gate driver pins. It arms cleanly at a deadtime boundary and suppresses leg pulses shorter than a minimum width. It blanks both gates on shoot-through or a filtered external overcurrent fault, and holds the bridge off in a latched fault state until software clears it.

## Interface
- MIN_PULSE, 10: minimum on-time (cycles) a leg input must hold before its gate turns on; range 1..2^CNT_W-1
- FAULT_FILTER, 4: consecutive synchronized low samples of i_fault_n required to declare a fault; range 1..2^CNT_W-1
- CNT_W, 8: width of the pulse and fault-filter counters
- i_clk  in  1  sole clock
- i_reset_n  in  1  reset, synchronous, active-low
- i_enable  in  1  arm request; level-sensitive
- i_pwm_high  in  1  high-side leg from PWM generator
- i_pwm_low  in  1  low-side leg from PWM generator
- i_fault_n  in  1  external overcurrent, active-low, asynchronous to i_clk
- i_fault_clear  in  1  fault clear request, sampled level
- o_gate_high  out  1  high-side gate drive
- o_gate_low  out  1  low-side gate drive
- o_ready  out  1  high while in RUN
- o_fault  out  1  latched fault flag
- o_fault_code  out  2  bit0 external fault, bit1 shoot-through; sticky while in FAULT

## Operation
- States: DISARMED, ARMING, RUN, FAULT. Reset forces DISARMED; every output 0; counters 0; synchronizer flops 1.
- DISARMED -> ARMING when i_enable=1.
- ARMING -> RUN on the first edge sampling i_pwm_high=0 and i_pwm_low=0, i.e. inside a deadtime window.
- ARMING/RUN -> DISARMED when i_enable=0.
- Any non-FAULT state -> FAULT when either condition holds:
  - filtered external fault asserted;
  - in ARMING or RUN, both leg inputs sampled 1 in the same cycle (shoot-through).
- FAULT -> DISARMED only when i_fault_clear=1, i_enable=0, and the filtered external fault is inactive. This forces a deliberate re-arm.
- Priority at each edge: reset > fault entry > enable drop > clear.
- Fault code bits set on each detected cause and OR in further causes while in FAULT. Code and o_fault clear only on FAULT->DISARMED or reset.
- Leg filter, per leg, held cleared outside RUN:
  - counter counts consecutive high samples and saturates at MIN_PULSE;
  - gate turns on once the count reaches MIN_PULSE;
  - gate turns off on the first low sample.
- Gate outputs are the filter outputs gated by state==RUN and registered. o_gate_high and o_gate_low are never 1 together; interlock logic enforces this structurally.
- i_fault_n passes through a 2-flop synchronizer. The filter counter counts consecutive synchronized lows, resets on any high, and saturates at FAULT_FILTER.

## Timing
- Leg rising edge sampled at edge k -> gate high after edge k+MIN_PULSE-1. Falling edge sampled at edge k -> gate low after edge k.
- Leg pulses of MIN_PULSE-1 cycles or fewer produce no gate pulse. A held-high leg yields a gate pulse MIN_PULSE-1 cycles shorter than the input, which extends the effective deadtime.
- Shoot-through sampled at edge k -> both gates 0, o_fault=1, code bit1 set, all after edge k.
- i_fault_n falls before edge 1 and stays low -> FAULT entered, gates 0 after edge FAULT_FILTER+2.
- o_ready follows the state register with no added latency.
- Reset asserted mid-RUN -> all outputs 0 after the next edge, regardless of leg inputs.

## Configuration
- PWM_GATE_GUARD_FAULT_COUNT_EN defined:
  - adds output o_fault_count (8 bits);
  - increments by 1 on each entry into FAULT and saturates at 255;
  - cleared only by reset.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package pwm_pkg holds:
  - the state enum (DISARMED, ARMING, RUN, FAULT);
  - fault-code bit constants FAULT_EXT=0 and FAULT_SHOOT=1.
- One sub-module, pwm_leg_filter (min-pulse counter plus output flop), instantiated twice with parameters MIN_PULSE and CNT_W and inputs clear, leg_in, gate_out.

## Test plan
- Reset/arm: reset low 3 cycles -> all outputs 0. i_enable=1 while i_pwm_high=1 -> stays ARMING (o_ready=0); both legs low -> o_ready=1 after that edge.
- Min pulse (MIN_PULSE=10): i_pwm_high high 40 cycles -> o_gate_high high 31 cycles, starting 9 edges after the rise. A 9-cycle pulse -> o_gate_high stays 0.
- Shoot-through: in RUN, both legs 1 for one cycle -> both gates 0 after that edge, o_fault=1, o_fault_code=2'b10.
- External fault (FAULT_FILTER=4): i_fault_n low 3 cycles -> no fault. Held low -> gates 0 and code 2'b01 after edge 6.
- Clear: i_fault_clear=1 with i_enable=1 -> remains FAULT. i_enable=0, i_fault_n=1, i_fault_clear=1 -> DISARMED, o_fault=0. With the macro defined, o_fault_count=2 after two fault entries.
- Reset mid-run: i_reset_n low while o_gate_high=1 -> all outputs 0 after the next edge; o_fault_count=0.
